// File: rtl/mic_repeater_ctrl_if.sv
// Word-wide BRAM port of the microphone repeater: the controller is the master,
// the block RAM (or its model) is the slave.
interface mic_repeater_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;
    logic [15:0]       mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/mic_repeater_ctrl.sv
// PDM microphone record/playback controller: packs microphone bits into 16-bit
// BRAM words while recording and streams them back MSB-first to anout in playback.
module mic_repeater_ctrl #(
    parameter int CLK_DIV = 20,
    parameter int ADDR_W  = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rec_start,
    input  logic                 play_start,
    input  logic                 stop,
    input  logic                 micro_data,
    output logic                 micro_clk,
    output logic                 lrsel,
    mic_repeater_ctrl_if.master  mem,
    output logic                 anout,
    output logic                 audio_sd,
    output logic [1:0]           state,
    output logic [ADDR_W:0]      rec_len
);

    localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [DIV_W-1:0]   div_cnt_r;
    logic               micro_clk_r;
    logic               mic_data_r;
    logic               tick_s;
    logic               rec_enter_s;
    logic               play_enter_s;
    logic               play_end_s;
    logic               last_word_s;
    logic [ADDR_W-1:0]  wr_addr_r;
    logic [3:0]         bit_cnt_r;
    logic [15:0]        rec_sh_r;
    logic [ADDR_W-1:0]  mem_addr_r;
    logic [15:0]        mem_wdata_r;
    logic               mem_we_r;
    logic [ADDR_W:0]    rec_len_r;
    logic [ADDR_W-1:0]  word_idx_r;
    logic [3:0]         play_bit_r;
    logic [15:0]        play_sh_r;
    logic [15:0]        pf_r;
    logic               rd_p1_r;
    logic               rd_p2_r;
    logic               play_run_r;
    logic               audio_sd_r;

    // A bit period ends on the cycle in which micro_clk is about to fall.
    assign tick_s      = (div_cnt_r == DIV_LAST) && micro_clk_r;
    assign last_word_s = (({1'b0, word_idx_r} + LEN_ONE) == rec_len_r);
    assign play_end_s  = tick_s && play_run_r && (play_bit_r == 4'd15) && last_word_s;

    // Free-running micro_clk divider and one-cycle registration of the PDM input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r   <= {DIV_W{1'b0}};
            micro_clk_r <= 1'b0;
            mic_data_r  <= 1'b0;
        end else begin
            mic_data_r <= micro_data;
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r   <= {DIV_W{1'b0}};
                micro_clk_r <= ~micro_clk_r;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_ONE;
            end
        end
    end

    // Next-state decode; record wins over play, and commands outside IDLE are ignored.
    always_comb begin
        state_next_s = state_r;
        rec_enter_s  = 1'b0;
        play_enter_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rec_start) begin
                    state_next_s = ST_RECORD;
                    rec_enter_s  = 1'b1;
                end else if (play_start && (rec_len_r != LEN_ZERO)) begin
                    state_next_s = ST_PLAY;
                    play_enter_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RECORD: begin
                if (stop) begin
                    state_next_s = ST_IDLE;
                end else if (mem_we_r && (wr_addr_r == ADDR_LAST)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RECORD;
                end
            end
            ST_PLAY: begin
                if (stop || play_end_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_PLAY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register plus the amplifier enable, which follows PLAY exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            audio_sd_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            audio_sd_r <= (state_next_s == ST_PLAY);
        end
    end

    // Record packing/writes and playback fetch/shift share the BRAM address register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_addr_r   <= {ADDR_W{1'b0}};
            bit_cnt_r   <= 4'd0;
            rec_sh_r    <= 16'd0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 16'd0;
            mem_we_r    <= 1'b0;
            rec_len_r   <= LEN_ZERO;
            word_idx_r  <= {ADDR_W{1'b0}};
            play_bit_r  <= 4'd0;
            play_sh_r   <= 16'd0;
            pf_r        <= 16'd0;
            rd_p1_r     <= 1'b0;
            rd_p2_r     <= 1'b0;
            play_run_r  <= 1'b0;
        end else begin
            mem_we_r <= 1'b0;
            if (rec_enter_s) begin
                wr_addr_r <= {ADDR_W{1'b0}};
                bit_cnt_r <= 4'd0;
                rec_len_r <= LEN_ZERO;
                rec_sh_r  <= 16'd0;
            end else if (state_r == ST_RECORD) begin
                // A word already strobed still counts even if stop lands on its write cycle.
                if (mem_we_r) begin
                    rec_len_r <= rec_len_r + LEN_ONE;
                    if (wr_addr_r != ADDR_LAST) begin
                        wr_addr_r <= wr_addr_r + ADDR_ONE;
                    end
                end
                if (tick_s && !stop) begin
                    rec_sh_r  <= {rec_sh_r[14:0], mic_data_r};
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                    if (bit_cnt_r == 4'd15) begin
                        mem_wdata_r <= {rec_sh_r[14:0], mic_data_r};
                        mem_addr_r  <= wr_addr_r;
                        mem_we_r    <= 1'b1;
                    end
                end
            end
            if (play_enter_s) begin
                mem_addr_r <= {ADDR_W{1'b0}};
                word_idx_r <= {ADDR_W{1'b0}};
                play_bit_r <= 4'd0;
                play_sh_r  <= 16'd0;
                rd_p1_r    <= 1'b1;
                rd_p2_r    <= 1'b0;
                play_run_r <= 1'b0;
            end else if (state_r == ST_PLAY) begin
                if (state_next_s != ST_PLAY) begin
                    play_sh_r  <= 16'd0;
                    play_run_r <= 1'b0;
                    rd_p1_r    <= 1'b0;
                    rd_p2_r    <= 1'b0;
                end else begin
                    rd_p1_r <= 1'b0;
                    rd_p2_r <= rd_p1_r;
                    // Bit ticks are held off until word 0 is in the shift register.
                    if (rd_p2_r) begin
                        if (play_run_r) begin
                            pf_r <= mem.mem_rdata;
                        end else begin
                            play_sh_r  <= mem.mem_rdata;
                            play_run_r <= 1'b1;
                        end
                    end
                    if (tick_s && play_run_r) begin
                        if (play_bit_r == 4'd15) begin
                            play_sh_r  <= pf_r;
                            play_bit_r <= 4'd0;
                            word_idx_r <= word_idx_r + ADDR_ONE;
                        end else begin
                            play_sh_r  <= {play_sh_r[14:0], 1'b0};
                            play_bit_r <= play_bit_r + 4'd1;
                            if ((play_bit_r == 4'd7) && !last_word_s) begin
                                mem_addr_r <= word_idx_r + ADDR_ONE;
                                rd_p1_r    <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign micro_clk     = micro_clk_r;
    assign lrsel         = 1'b0;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;
    assign mem.mem_we    = mem_we_r;
    assign anout         = play_sh_r[15];
    assign audio_sd      = audio_sd_r;
    assign state         = state_r;
    assign rec_len       = rec_len_r;

endmodule

// File: tb/tb_mic_repeater_ctrl.sv
// Bench for mic_repeater_ctrl with a 4-word memory: divider timing, recording,
// full-memory stop, abort, playback bit stream, priority and reset behaviour.
module tb_mic_repeater_ctrl;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          rec_start;
    logic          play_start;
    logic          stop;
    logic          micro_data;
    logic          micro_clk;
    logic          lrsel;
    logic          anout;
    logic          audio_sd;
    logic [1:0]    state;
    logic [AW:0]   rec_len;

    int total = 0;
    int bad   = 0;
    int n_writes = 0;

    logic [AW+15:0] exp_q [$];
    logic           bit_q [$];
    logic [15:0]    mem_model [4];

    mic_repeater_ctrl_if #(.ADDR_W(AW)) mif ();

    mic_repeater_ctrl #(.CLK_DIV(20), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rec_start  (rec_start),
        .play_start (play_start),
        .stop       (stop),
        .micro_data (micro_data),
        .micro_clk  (micro_clk),
        .lrsel      (lrsel),
        .mem        (mif),
        .anout      (anout),
        .audio_sd   (audio_sd),
        .state      (state),
        .rec_len    (rec_len)
    );

    always #5 clk = ~clk;

    // Block RAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (mif.mem_we === 1'b1) mem_model[mif.mem_addr] <= mif.mem_wdata;
        mif.mem_rdata <= mem_model[mif.mem_addr];
    end

    // Write scoreboard: every strobe must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (mif.mem_we === 1'b1) begin
            logic [AW+15:0] e;
            n_writes++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got addr=%0d data=%h, no write expected", mif.mem_addr, mif.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mif.mem_addr, mif.mem_wdata} !== e)
                    begin bad++; $display("FAIL write got addr=%0d data=%h, want addr=%0d data=%h", mif.mem_addr, mif.mem_wdata, e[AW+15:16], e[15:0]); end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_edge(input logic rising, input string name);
        logic p;
        bit   ok;
        ok = 1'b0;
        p  = micro_clk;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if ((rising && !p && micro_clk) || (!rising && p && !micro_clk)) begin ok = 1'b1; break; end
            p = micro_clk;
        end
        if (!ok) begin total++; bad++; $display("FAIL %s_timeout got no micro_clk edge, want one within 200 cycles", name); end
    endtask

    task automatic count_until(input logic level, output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (micro_clk === level) break;
        end
    endtask

    task automatic rec_stream(input int nbits, input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
        logic [15:0] words [4];
        logic [15:0] cur;
        words = '{w0, w1, w2, w3};
        for (int i = 0; i < nbits; i++) begin
            cur = words[i / 16];
            micro_data = cur[15 - (i % 16)];
            wait_edge(1'b0, "rec_bit");
            if ((i % 16) == 15) begin
                @(posedge clk); #1;
                total++;
                if (rec_len !== 3'(i / 16 + 1)) begin bad++; $display("FAIL rec_len_step got %0d want %0d", rec_len, i / 16 + 1); end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; rec_start = 1'b0; play_start = 1'b0; stop = 1'b0; micro_data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({micro_clk, anout, audio_sd, mif.mem_we, state, rec_len, mif.mem_addr, mif.mem_wdata} !== 27'd0)
            begin bad++; $display("FAIL reset_outputs got clk=%b an=%b sd=%b we=%b st=%0d len=%0d addr=%0d wd=%h, want all 0", micro_clk, anout, audio_sd, mif.mem_we, state, rec_len, mif.mem_addr, mif.mem_wdata); end
        total++;
        if (lrsel !== 1'b0) begin bad++; $display("FAIL lrsel got %b want 0", lrsel); end
    endtask

    task automatic test_divider();
        int n;
        @(negedge clk); reset = 1'b1;
        count_until(1'b1, n);
        total++;
        if (n !== 20) begin bad++; $display("FAIL first_rise got %0d cycles want 20", n); end
        count_until(1'b0, n);
        total++;
        if (n !== 20) begin bad++; $display("FAIL high_time got %0d want 20", n); end
        count_until(1'b1, n);
        total++;
        if (n !== 20) begin bad++; $display("FAIL low_time got %0d want 20", n); end
        begin
            int m;
            count_until(1'b0, m);
            total++;
            if (n + m !== 40) begin bad++; $display("FAIL tick_spacing got %0d want 40", n + m); end
        end
    endtask

    task automatic test_play_empty();
        play_start = 1'b1; @(posedge clk); #1; play_start = 1'b0;
        total++;
        if (state !== 2'd0) begin bad++; $display("FAIL play_empty_state got %0d want 0", state); end
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (audio_sd !== 1'b0) begin bad++; $display("FAIL play_empty_sd got %b want 0", audio_sd); end
    endtask

    task automatic test_record_full();
        int w0;
        wait_edge(1'b0, "sync");
        for (int k = 0; k < 4; k++) exp_q.push_back({2'(k), 16'hA5C3});
        w0 = n_writes;
        rec_start = 1'b1; @(posedge clk); #1; rec_start = 1'b0;
        total++;
        if (state !== 2'd1) begin bad++; $display("FAIL rec_enter_state got %0d want 1", state); end
        rec_stream(64, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3);
        total++;
        if (state !== 2'd0) begin bad++; $display("FAIL full_state got %0d want 0", state); end
        repeat (100) @(posedge clk);
        #1;
        total++;
        if ((n_writes - w0) !== 4) begin bad++; $display("FAIL full_write_count got %0d want 4", n_writes - w0); end
        total++;
        if ({rec_len, mif.mem_we, state} !== {3'd4, 1'b0, 2'd0}) begin bad++; $display("FAIL full_final got len=%0d we=%b st=%0d want len=4 we=0 st=0", rec_len, mif.mem_we, state); end
    endtask

    task automatic test_stop_and_play();
        int w0;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        e;
        d0 = 16'h3C96;
        d1 = 16'h5A0F;
        wait_edge(1'b0, "sync");
        exp_q.push_back({2'd0, d0});
        exp_q.push_back({2'd1, d1});
        w0 = n_writes;
        rec_start = 1'b1; @(posedge clk); #1; rec_start = 1'b0;
        total++;
        if (rec_len !== 3'd0) begin bad++; $display("FAIL rec_clear_len got %0d want 0", rec_len); end
        rec_stream(39, d0, d1, 16'hFFFF, 16'hFFFF);
        stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
        total++;
        if ({state, rec_len} !== {2'd0, 3'd2}) begin bad++; $display("FAIL stop_mid got st=%0d len=%0d want st=0 len=2", state, rec_len); end
        repeat (400) @(posedge clk);
        #1;
        total++;
        if ((n_writes - w0) !== 2) begin bad++; $display("FAIL stop_write_count got %0d want 2", n_writes - w0); end
        for (int i = 15; i >= 0; i--) bit_q.push_back(d0[i]);
        for (int i = 15; i >= 0; i--) bit_q.push_back(d1[i]);
        wait_edge(1'b0, "sync");
        play_start = 1'b1; @(posedge clk); #1; play_start = 1'b0;
        total++;
        if ({state, audio_sd} !== {2'd2, 1'b1}) begin bad++; $display("FAIL play_enter got st=%0d sd=%b want st=2 sd=1", state, audio_sd); end
        for (int k = 0; k < 32; k++) begin
            wait_edge(1'b1, "play_bit");
            e = bit_q.pop_front();
            total++;
            if (anout !== e) begin bad++; $display("FAIL play_bit%0d got %b want %b", k, anout, e); end
        end
        wait_edge(1'b1, "play_end");
        total++;
        if ({anout, audio_sd, state} !== {1'b0, 1'b0, 2'd0}) begin bad++; $display("FAIL play_end got an=%b sd=%b st=%0d want 0 0 0", anout, audio_sd, state); end
    endtask

    task automatic test_reset_mid_play();
        wait_edge(1'b0, "sync");
        play_start = 1'b1; @(posedge clk); #1; play_start = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        total++;
        if ({state, audio_sd} !== {2'd2, 1'b1}) begin bad++; $display("FAIL mid_play got st=%0d sd=%b want st=2 sd=1", state, audio_sd); end
        #3;
        reset = 1'b0;
        #1;
        total++;
        if ({micro_clk, anout, audio_sd, mif.mem_we, state, mif.mem_addr, mif.mem_wdata} !== 24'd0)
            begin bad++; $display("FAIL async_reset got clk=%b an=%b sd=%b we=%b st=%0d addr=%0d wd=%h want all 0", micro_clk, anout, audio_sd, mif.mem_we, state, mif.mem_addr, mif.mem_wdata); end
        total++;
        if (rec_len !== 3'd0) begin bad++; $display("FAIL reset_rec_len got %0d want 0", rec_len); end
        @(negedge clk); reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        play_start = 1'b1; @(posedge clk); #1; play_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({state, audio_sd} !== {2'd0, 1'b0}) begin bad++; $display("FAIL play_after_reset got st=%0d sd=%b want st=0 sd=0", state, audio_sd); end
    endtask

    task automatic test_priority();
        rec_start = 1'b1; play_start = 1'b1; @(posedge clk); #1; rec_start = 1'b0; play_start = 1'b0;
        total++;
        if (state !== 2'd1) begin bad++; $display("FAIL priority got %0d want 1", state); end
        play_start = 1'b1; @(posedge clk); #1; play_start = 1'b0;
        total++;
        if (state !== 2'd1) begin bad++; $display("FAIL play_in_record got %0d want 1", state); end
        stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
        total++;
        if ({state, rec_len} !== {2'd0, 3'd0}) begin bad++; $display("FAIL stop_early got st=%0d len=%0d want 0 0", state, rec_len); end
        stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
        total++;
        if (state !== 2'd0) begin bad++; $display("FAIL stop_idle got %0d want 0", state); end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_play_empty();
        test_record_full();
        test_stop_and_play();
        test_reset_mid_play();
        test_priority();
        total++;
        if (exp_q.size() !== 0) begin bad++; $display("FAIL pending_writes got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mic_repeater_ctrl.md
MIC_REPEATER_CTRL -- requirements
Module: mic_repeater_ctrl

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 20: system-clock cycles per micro_clk half-period (100 MHz / 40 = 2.5 MHz).
REQ-002 The module SHALL have parameter ADDR_W, default 14: word-address width. DEPTH = 2^ADDR_W words of 16 PDM bits.
REQ-003 Port clk, input, 1: 100 MHz system clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port rec_start, input, 1: single-cycle record request (already debounced).
REQ-006 Port play_start, input, 1: single-cycle playback request.
REQ-007 Port stop, input, 1: single-cycle abort request.
REQ-008 Port micro_data, input, 1: PDM data from microphone.
REQ-009 Port micro_clk, output, 1: microphone clock.
REQ-010 Port lrsel, output, 1: microphone channel select, constant 0.
REQ-011 Port mem_addr, output, ADDR_W: BRAM word address.
REQ-012 Port mem_wdata, output, 16: BRAM write data.
REQ-013 Port mem_we, output, 1: BRAM write strobe, one cycle per word.
REQ-014 Port mem_rdata, input, 16: BRAM read data, valid 1 cycle after mem_addr.
REQ-015 Port anout, output, 1: PDM bit to audio low-pass output.
REQ-016 Port audio_sd, output, 1: amplifier enable, 1 only in PLAY.
REQ-017 Port state, output, 2: IDLE=0, RECORD=1, PLAY=2.
REQ-018 Port rec_len, output, ADDR_W+1: number of complete words held in memory.

Function
REQ-019 The divider SHALL count 0..CLK_DIV-1 continuously and toggle micro_clk when the count reaches CLK_DIV-1.
REQ-020 bit_tick SHALL pulse for one cycle on every 1->0 toggle of micro_clk, once per 2*CLK_DIV cycles.
REQ-021 On bit_tick, micro_data SHALL be sampled. The value used is the micro_data value registered on the preceding clk edge.
REQ-022 In IDLE: rec_start SHALL go to RECORD. Otherwise, play_start with rec_len>0 SHALL go to PLAY. play_start with rec_len=0 SHALL be ignored. If rec_start and play_start arrive together, rec_start SHALL win.
REQ-023 Entering RECORD SHALL clear the write address, the bit counter and rec_len.
REQ-024 RECORD SHALL shift the sampled bits MSB-first into a 16-bit register.
REQ-025 On the 16th bit, RECORD SHALL drive mem_wdata and mem_addr, pulse mem_we for 1 cycle, then increment the address and rec_len.
REQ-026 After writing word DEPTH-1, RECORD SHALL return to IDLE with rec_len = DEPTH. The address SHALL NOT wrap.
REQ-027 stop during RECORD SHALL return to IDLE next cycle and discard any partial word. rec_len SHALL keep the count of complete words.
REQ-028 Entering PLAY SHALL set mem_addr=0 and load the first word into the output shift register before the first play bit_tick. The next word SHALL be prefetched at the word midpoint (bit 8).
REQ-029 PLAY SHALL drive anout with the shift register MSB and shift on each bit_tick. At each word boundary it SHALL load the prefetched word with no gap bit.
REQ-030 After bit 15 of word rec_len-1, PLAY SHALL return to IDLE.
REQ-031 stop during PLAY SHALL return to IDLE next cycle.
REQ-032 In IDLE and RECORD, anout=0 and audio_sd=0.
REQ-033 mem_we SHALL be 0 outside RECORD.
REQ-034 rec_start or play_start arriving while not in IDLE SHALL be ignored.
REQ-035 stop in IDLE SHALL have no effect.

Reset
REQ-036 While reset=0, all outputs SHALL be 0: micro_clk, mem_addr, mem_wdata, mem_we, anout, audio_sd, state=IDLE, rec_len, the divider and all counters.
REQ-037 Reset asserted mid-RECORD or mid-PLAY SHALL abort immediately and leave rec_len=0. Memory contents are not cleared.
REQ-038 After reset deasserts, micro_clk SHALL first rise CLK_DIV cycles later.

Verification
REQ-039 Divider check: CLK_DIV=20 -> micro_clk period 40 cycles, 50% duty; bit_tick spacing 40 cycles.
REQ-040 Record check: rec_start, micro_data pattern 0xA5C3 repeated -> mem_we pulses with mem_wdata=0xA5C3 at addresses 0,1,2 …; rec_len increments per word.
REQ-041 Full-memory check: ADDR_W=2, record runs uninterrupted -> exactly 4 writes, then state=IDLE, rec_len=4, mem_we stays 0.
REQ-042 Stop-mid-word check: stop after 2 words + 7 bits -> IDLE, rec_len=2, no third write. Then play_start -> anout replays exactly 32 bits, MSB-first, with no gaps, then audio_sd=0.
REQ-043 Play-empty and priority check: play_start with rec_len=0 -> state stays 0. rec_start and play_start in the same cycle -> state=1.
REQ-044 Reset-mid-operation check: reset pulsed low during PLAY -> all outputs 0 asynchronously, rec_len=0, and a later play_start is ignored.
